// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory address/data plus the redirect and decode handshake.
// master = fetch unit, slave = memory/decode/execute side.
interface instruction_fetch_if #(
    parameter int unsigned ADDRESS_WIDTH = 5
);
    logic [ADDRESS_WIDTH-1:0] instr_mem_addr;
    logic [31:0]              instr_mem_data;
    logic                     ifu_redirect;
    logic [31:0]              ifu_redirect_pc;
    logic                     ifu_valid;
    logic                     ifu_ready;
    logic [31:0]              ifu_instr;
    logic [31:0]              ifu_pc;
    logic                     ifu_halted;

    modport master (
        output instr_mem_addr, ifu_valid, ifu_instr, ifu_pc, ifu_halted,
        input  instr_mem_data, ifu_redirect, ifu_redirect_pc, ifu_ready
    );

    modport slave (
        input  instr_mem_addr, ifu_valid, ifu_instr, ifu_pc, ifu_halted,
        output instr_mem_data, ifu_redirect, ifu_redirect_pc, ifu_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the fetch PC, reads a combinational instruction memory and
// queues {pc, instr} for decode. Optional halt-on-zero-word behaviour: IFU_HALT_ON_ZERO_EN.
module instruction_fetch #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH   = 2
) (
    input logic                 ifu_clk,
    input logic                 ifu_rst_n,
    instruction_fetch_if.master bus
);
    localparam int unsigned     CntW   = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(QUEUE_DEPTH);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] count_q, count_d, tail;
    logic [31:0]     pc_q    [QUEUE_DEPTH];
    logic [31:0]     pc_d    [QUEUE_DEPTH];
    logic [31:0]     instr_q [QUEUE_DEPTH];
    logic [31:0]     instr_d [QUEUE_DEPTH];
    logic            valid, halted, pop, fetch;
    logic            unused_pc_bits;

`ifdef IFU_HALT_ON_ZERO_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

    assign valid = (count_q != '0);
    assign pop   = valid & bus.ifu_ready;
    assign fetch = !bus.ifu_redirect & !halted & ((count_q < DepthC) | pop);
    // Slot that receives the pushed word once the head has been shifted out.
    assign tail  = count_q - CntW'(pop);

    assign unused_pc_bits = ^bus.ifu_redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            pc_d[i]    = pc_q[i];
            instr_d[i] = instr_q[i];
        end

        if (bus.ifu_redirect) begin
            count_d    = '0;
            fetch_pc_d = {bus.ifu_redirect_pc[31:2], 2'b00};
            state_d    = StRun;
        end else begin
            if (pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                    pc_d[i]    = pc_q[i + 1];
                    instr_d[i] = instr_q[i + 1];
                end
                pc_d[QUEUE_DEPTH - 1]    = '0;
                instr_d[QUEUE_DEPTH - 1] = '0;
            end
            if (fetch) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (CntW'(i) == tail) begin
                        pc_d[i]    = fetch_pc_q;
                        instr_d[i] = bus.instr_mem_data;
                    end
                end
                fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef IFU_HALT_ON_ZERO_EN
                // The zero word itself is still delivered; only later fetches stop.
                if (bus.instr_mem_data == 32'h0) begin
                    state_d = StHalt;
                end
`endif
            end
            count_d = count_q + CntW'(fetch) - CntW'(pop);
        end
    end

    always_ff @(posedge ifu_clk or negedge ifu_rst_n) begin
        if (!ifu_rst_n) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]    <= pc_d[i];
                instr_q[i] <= instr_d[i];
            end
        end
    end

    assign bus.instr_mem_addr = fetch_pc_q[ADDRESS_WIDTH+1:2];
    assign bus.ifu_valid      = valid;
    assign bus.ifu_instr      = valid ? instr_q[0] : 32'h0;
    assign bus.ifu_pc         = valid ? pc_q[0] : 32'h0;
    assign bus.ifu_halted     = halted;
endmodule
